// File: rtl/cic_pkg.sv
// Constants shared by the CIC integrator chain and the decimating comb section,
// plus helpers for the output slice offset and the round-half-up constant.
package cic_pkg;

    localparam int CIC_NUM_STAGES     = 3;
    localparam int CIC_DATA_WIDTH_IN  = 16;
    localparam int CIC_DATA_WIDTH_OUT = 16;
    localparam int CIC_DIFF_DELAY     = 1;
    localparam int CIC_DEC_WIDTH      = 5;

    // LSB of the internal word that lands on bit 0 of the output.
    function automatic int slice_offset(input int width_in, input int width_out);
        return width_in - width_out;
    endfunction

    // Half an output LSB, expressed in internal LSBs; zero when nothing is dropped.
    function automatic longint round_const(input int width_in, input int width_out);
        if (width_in > width_out) begin
            return longint'(1) << (width_in - width_out - 1);
        end
        return 0;
    endfunction

endpackage

// File: rtl/cic_comb_decim_if.sv
// Sample-side and output-side signals of the decimating comb section.
// master drives samples and the decimation factor; slave is the comb section.
interface cic_comb_decim_if
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = CIC_DATA_WIDTH_IN,
    parameter int DATA_WIDTH_OUT = CIC_DATA_WIDTH_OUT,
    parameter int DEC_WIDTH      = CIC_DEC_WIDTH
);

    logic                      en;
    logic [DATA_WIDTH_IN-1:0]  in;
    logic [DEC_WIDTH-1:0]      dec_factor;
    logic [DATA_WIDTH_OUT-1:0] out;
    logic                      valid_out;

    modport master (
        output en,
        output in,
        output dec_factor,
        input  out,
        input  valid_out
    );

    modport slave (
        input  en,
        input  in,
        input  dec_factor,
        output out,
        output valid_out
    );

endinterface

// File: rtl/cic_comb_stage.sv
// One comb stage y[n] = x[n] - x[n-DIFF_DELAY], advancing only on a valid
// input; arithmetic wraps modulo 2^DATA_WIDTH.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH = CIC_DATA_WIDTH_IN,
    parameter int DIFF_DELAY = CIC_DIFF_DELAY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] dline [DIFF_DELAY];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the shift below needs no ordering care.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            // NOTE: the delay line is a memory that is explicitly reset, since
            // the first post-reset result must be taken against zero history.
            for (int i = 0; i < DIFF_DELAY; i++) begin
                dline[i] <= '0;
            end
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data - dline[DIFF_DELAY-1];
            dline[0]  <= in_data;
            for (int i = 1; i < DIFF_DELAY; i++) begin
                dline[i] <= dline[i-1];
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cic_comb_decim.sv
// Decimating comb section: downsample by runtime R, NUM_STAGES comb stages,
// output slice. Define CIC_COMB_ROUND_EN for round-half-up with saturation.
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = CIC_DATA_WIDTH_IN,
    parameter int DATA_WIDTH_OUT = CIC_DATA_WIDTH_OUT,
    parameter int NUM_STAGES     = CIC_NUM_STAGES,
    parameter int DIFF_DELAY     = CIC_DIFF_DELAY,
    parameter int DEC_WIDTH      = CIC_DEC_WIDTH
) (
    input logic              clk,
    input logic              rst,
    cic_comb_decim_if.slave  bus
);

    localparam int OFFSET = slice_offset(DATA_WIDTH_IN, DATA_WIDTH_OUT);

    logic [DEC_WIDTH-1:0]     cnt;
    logic [DEC_WIDTH-1:0]     r_latched;
    logic [DEC_WIDTH-1:0]     dec_eff;
    logic                     accept;
    logic                     cap_valid;
    logic [DATA_WIDTH_IN-1:0] cap_data;
    logic                     stg_valid [NUM_STAGES];
    logic [DATA_WIDTH_IN-1:0] stg_data  [NUM_STAGES];
    logic [DATA_WIDTH_IN-1:0] result;

    // NOTE: dec_eff gets its default before the conditional override so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_eff = bus.dec_factor;
        if (bus.dec_factor == '0) begin
            dec_eff = DEC_WIDTH'(1);
        end
    end

    // r_latched never drops below 1, so the subtraction cannot underflow.
    assign accept = bus.en && (cnt == r_latched - DEC_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            r_latched <= DEC_WIDTH'(1);
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= accept;
            if (accept) begin
                cnt       <= '0;
                r_latched <= dec_eff;
                cap_data  <= bus.in;
            end else if (bus.en) begin
                cnt <= cnt + DEC_WIDTH'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                     stage_in_valid;
        logic [DATA_WIDTH_IN-1:0] stage_in_data;

        if (k == 0) begin : g_first
            assign stage_in_valid = cap_valid;
            assign stage_in_data  = cap_data;
        end else begin : g_chain
            assign stage_in_valid = stg_valid[k-1];
            assign stage_in_data  = stg_data[k-1];
        end

        cic_comb_stage #(
            .DATA_WIDTH (DATA_WIDTH_IN),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (stage_in_valid),
            .in_data   (stage_in_data),
            .out_valid (stg_valid[k]),
            .out_data  (stg_data[k])
        );
    end

    assign result        = stg_data[NUM_STAGES-1];
    assign bus.valid_out = stg_valid[NUM_STAGES-1];

`ifdef CIC_COMB_ROUND_EN
    localparam logic [DATA_WIDTH_IN:0] ROUND_ADD =
        (DATA_WIDTH_IN+1)'(round_const(DATA_WIDTH_IN, DATA_WIDTH_OUT));

    logic [DATA_WIDTH_IN:0]    rounded;
    logic [DATA_WIDTH_OUT-1:0] out_sel;

    // One guard bit catches the overflow of the rounding add; clamp on it.
    always_comb begin
        rounded = {result[DATA_WIDTH_IN-1], result} + ROUND_ADD;
        out_sel = rounded[DATA_WIDTH_IN-1 -: DATA_WIDTH_OUT];
        if (rounded[DATA_WIDTH_IN] != rounded[DATA_WIDTH_IN-1]) begin
            out_sel = rounded[DATA_WIDTH_IN] ? {1'b1, {(DATA_WIDTH_OUT-1){1'b0}}}
                                             : {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};
        end
    end

    assign bus.out = out_sel;
`else
    assign bus.out = result[OFFSET +: DATA_WIDTH_OUT];
`endif

endmodule

// File: tb/tb_cic_comb_decim.sv
// Directed bench for cic_comb_decim: table-driven frames plus hand-written
// reset and wrap-around sequences; a second instance has a single stage.
module tb_cic_comb_decim;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cic_comb_decim_if #(.DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(16), .DEC_WIDTH(5)) bus_a ();
    cic_comb_decim_if #(.DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(16), .DEC_WIDTH(5)) bus_b ();

    cic_comb_decim #(
        .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(16), .NUM_STAGES(3), .DIFF_DELAY(1), .DEC_WIDTH(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    cic_comb_decim #(
        .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(16), .NUM_STAGES(1), .DIFF_DELAY(1), .DEC_WIDTH(5)
    ) dut_n1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic        en;
        logic [15:0] din;
        logic [4:0]  dec;
        logic        exp_valid;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic en, input logic [15:0] din, input logic [4:0] dec,
                           input logic exp_valid, input logic [15:0] exp_out);
        vec_t v;
        v.en = en; v.din = din; v.dec = dec; v.exp_valid = exp_valid; v.exp_out = exp_out;
        vecs.push_back(v);
    endtask

    task automatic run_table(input string name);
        pulses = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            bus_a.en         = vecs[i].en;
            bus_a.in         = vecs[i].din;
            bus_a.dec_factor = vecs[i].dec;
            tick();
            if (bus_a.valid_out === 1'b1) pulses++;
            check($sformatf("%s[%0d].valid", name, i), {15'd0, bus_a.valid_out},
                  {15'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("%s[%0d].out", name, i), bus_a.out, vecs[i].exp_out);
            end
        end
        vecs.delete();
        bus_a.en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus_a.en = 1'b0; bus_a.in = '0; bus_a.dec_factor = 5'd1;
        bus_b.en = 1'b0; bus_b.in = '0; bus_b.dec_factor = 5'd1;

        // Reset state
        do_reset();
        check("reset.out", bus_a.out, 16'h0000);
        check("reset.valid", {15'd0, bus_a.valid_out}, 16'd0);
        check("reset_n1.valid", {15'd0, bus_b.valid_out}, 16'd0);

        // Step of 5, R=1 via dec_factor=0: 5, -10, 5, 0, 0 from the 4th edge
        for (int i = 0; i < 8; i++) begin
            case (i)
                3:       add_vec(1'b1, 16'd5, 5'd0, 1'b1, 16'h0005);
                4:       add_vec(1'b1, 16'd5, 5'd0, 1'b1, 16'hFFF6);
                5:       add_vec(1'b1, 16'd5, 5'd0, 1'b1, 16'h0005);
                6, 7:    add_vec(1'b1, 16'd5, 5'd0, 1'b1, 16'h0000);
                default: add_vec(1'b1, 16'd5, 5'd0, 1'b0, 16'h0000);
            endcase
        end
        run_table("step");

        // Decimation R=4: one primer accept latches R=4, then in=0..15
        do_reset();
        bus_a.en = 1'b1; bus_a.in = 16'd0; bus_a.dec_factor = 5'd4;
        tick();
        bus_a.en = 1'b0;
        tick();
        tick();
        check("dec_primer.valid_early", {15'd0, bus_a.valid_out}, 16'd0);
        tick();
        check("dec_primer.valid", {15'd0, bus_a.valid_out}, 16'd1);
        check("dec_primer.out", bus_a.out, 16'h0000);
        for (int i = 0; i < 19; i++) begin
            case (i)
                6:       add_vec(1'b1, 16'(i), 5'd4, 1'b1, 16'h0003);
                10:      add_vec(1'b1, 16'(i), 5'd4, 1'b1, 16'hFFFE);
                14:      add_vec(1'b1, 16'(i), 5'd4, 1'b1, 16'hFFFF);
                18:      add_vec(1'b0, 16'd0,  5'd4, 1'b1, 16'h0000);
                default: add_vec(i < 16, i < 16 ? 16'(i) : 16'd0, 5'd4, 1'b0, 16'h0000);
            endcase
        end
        run_table("dec4");
        check("dec4.pulse_count", 16'(pulses), 16'd4);

        // en gaps, R=2: accepts every 4 cycles; non-accepted samples carry 99
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic        en_i;
            logic [15:0] din_i;
            en_i  = (i % 2) == 0;
            din_i = !en_i ? 16'd77 : ((i % 4) == 0 ? 16'd5 : 16'd99);
            case (i)
                3:       add_vec(en_i, din_i, 5'd2, 1'b1, 16'h0005);
                7:       add_vec(en_i, din_i, 5'd2, 1'b1, 16'hFFF6);
                11:      add_vec(en_i, din_i, 5'd2, 1'b1, 16'h0005);
                15:      add_vec(en_i, din_i, 5'd2, 1'b1, 16'h0000);
                default: add_vec(en_i, din_i, 5'd2, 1'b0, 16'h0000);
            endcase
        end
        run_table("gaps");

        // R change mid-frame: frame of 4 completes, then accepts every 2 en
        do_reset();
        for (int i = 0; i < 14; i++) begin
            logic [4:0] dec_i;
            logic       ev;
            dec_i = (i < 3) ? 5'd4 : 5'd2;
            ev    = (i == 3) || (i == 7) || (i == 9) || (i == 11) || (i == 13);
            add_vec(i < 11, 16'd0, dec_i, ev, 16'h0000);
        end
        run_table("rchg");

        // Reset with two samples in flight: no stale output, fresh step response
        do_reset();
        bus_a.en = 1'b1; bus_a.in = 16'd5; bus_a.dec_factor = 5'd1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst.valid", {15'd0, bus_a.valid_out}, 16'd0);
        check("midrst.out", bus_a.out, 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst.quiet[%0d]", i), {15'd0, bus_a.valid_out}, 16'd0);
        end
        tick();
        check("midrst.first.valid", {15'd0, bus_a.valid_out}, 16'd1);
        check("midrst.first.out", bus_a.out, 16'h0005);
        tick();
        check("midrst.second.out", bus_a.out, 16'hFFF6);
        bus_a.en = 1'b0;

        // Wrap-around on the single-stage instance: 0x8000 - 0x7FFF = 0x0001
        do_reset();
        bus_b.dec_factor = 5'd1;
        bus_b.en = 1'b1; bus_b.in = 16'h7FFF;
        tick();
        check("wrap.lat.valid", {15'd0, bus_b.valid_out}, 16'd0);
        bus_b.in = 16'h8000;
        tick();
        check("wrap.first.valid", {15'd0, bus_b.valid_out}, 16'd1);
        check("wrap.first.out", bus_b.out, 16'h7FFF);
        bus_b.en = 1'b0;
        tick();
        check("wrap.second.valid", {15'd0, bus_b.valid_out}, 16'd1);
        check("wrap.second.out", bus_b.out, 16'h0001);
        tick();
        check("wrap.idle.valid", {15'd0, bus_b.valid_out}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
